// File: rtl/multi_reg_seq.sv
// ============================================================================
// Module   : multi_reg_seq
// Brief    : Multi-register load/store sequencer (PUSH/POP/STM/LDM) with
//            base/stack-pointer writeback and unbounded memory wait states.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multi_reg_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [8:0]  reg_list,
    input  logic [31:0] base,
    input  logic [3:0]  base_reg,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  rf_raddr,
    input  logic [31:0] rf_rdata,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        sp_we,
    output logic [31:0] sp_wdata,
    output logic        pc_we,
    output logic [31:0] pc_wdata
);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_STM  = 2'b10;
    localparam logic [1:0] OP_LDM  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [3:0] f_popcount(input logic [8:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 9; i++) c = c + {3'd0, v[i]};
        return c;
    endfunction

    function automatic logic [3:0] f_lowest(input logic [8:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 8; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    // Slot 8 of the list is LR for PUSH and PC for POP.
    function automatic logic [3:0] f_reg(input logic [3:0] slot, input logic [1:0] o);
        return (slot == 4'd8) ? ((o == OP_POP) ? 4'd15 : 4'd14) : slot;
    endfunction

    state_t      r_state;
    logic [1:0]  r_op;
    logic [31:0] r_base;
    logic [3:0]  r_base_reg;
    logic [3:0]  r_n;
    logic [8:0]  r_rem;
    logic [3:0]  r_slot;
    logic        r_in_list;
    logic        r_busy, r_done, r_mem_req, r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_rf_raddr, r_rf_waddr;
    logic        r_rf_we, r_sp_we, r_pc_we;
    logic [31:0] r_rf_wdata, r_sp_wdata, r_pc_wdata;

    logic [8:0]  w_eff;
    logic [3:0]  w_n;
    logic [31:0] w_start_addr;
    logic [8:0]  w_rem_next;
    logic [3:0]  w_slot_first, w_slot_next;
    logic [31:0] w_span;
    logic        w_ack;

    assign w_eff        = {reg_list[8] & ~op[1], reg_list[7:0]};
    assign w_n          = f_popcount(w_eff);
    assign w_start_addr = (op == OP_PUSH) ? (base - {26'd0, w_n, 2'b00}) : base;
    assign w_slot_first = f_lowest(w_eff);
    assign w_rem_next   = r_rem & (r_rem - 9'd1);
    assign w_slot_next  = f_lowest(w_rem_next);
    assign w_span       = {26'd0, r_n, 2'b00};
    assign w_ack        = r_mem_req & mem_ack;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_op       <= 2'd0;
            r_base     <= 32'd0;
            r_base_reg <= 4'd0;
            r_n        <= 4'd0;
            r_rem      <= 9'd0;
            r_slot     <= 4'd0;
            r_in_list  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 32'd0;
            r_rf_raddr <= 4'd0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 4'd0;
            r_rf_wdata <= 32'd0;
            r_sp_we    <= 1'b0;
            r_sp_wdata <= 32'd0;
            r_pc_we    <= 1'b0;
            r_pc_wdata <= 32'd0;
        end else begin
            r_rf_we <= 1'b0;
            r_sp_we <= 1'b0;
            r_pc_we <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op       <= op;
                        r_base     <= base;
                        r_base_reg <= base_reg;
                        r_n        <= w_n;
                        r_rem      <= w_eff;
                        r_in_list  <= ~base_reg[3] & reg_list[base_reg[2:0]];
                        r_busy     <= 1'b1;
                        if (w_n != 4'd0) begin
                            r_state    <= S_XFER;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= ~op[0];
                            r_mem_addr <= w_start_addr;
                            r_slot     <= w_slot_first;
                            r_rf_raddr <= f_reg(w_slot_first, op);
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_XFER: begin
                    if (w_ack) begin
                        if (!r_mem_we) begin
                            if (r_slot == 4'd8) begin
                                r_pc_we    <= 1'b1;
                                r_pc_wdata <= mem_rdata & 32'hFFFF_FFFE;
                            end else begin
                                r_rf_we    <= 1'b1;
                                r_rf_waddr <= r_slot;
                                r_rf_wdata <= mem_rdata;
                            end
                        end
                        r_rem <= w_rem_next;
                        if (w_rem_next == 9'd0) begin
                            r_state    <= S_WB;
                            r_mem_req  <= 1'b0;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= 32'd0;
                            r_rf_raddr <= 4'd0;
                        end else begin
                            r_mem_addr <= r_mem_addr + 32'd4;
                            r_slot     <= w_slot_next;
                            r_rf_raddr <= f_reg(w_slot_next, r_op);
                        end
                    end
                end
                S_WB: begin
                    // The last load's register write occupies this cycle, so
                    // the base writeback is issued one cycle later.
                    case (r_op)
                        OP_PUSH: begin
                            r_sp_we    <= 1'b1;
                            r_sp_wdata <= r_base - w_span;
                        end
                        OP_POP: begin
                            r_sp_we    <= 1'b1;
                            r_sp_wdata <= r_base + w_span;
                        end
                        OP_STM: begin
                            r_rf_we    <= 1'b1;
                            r_rf_waddr <= r_base_reg;
                            r_rf_wdata <= r_base + w_span;
                        end
                        default: begin
                            if (!r_in_list) begin
                                r_rf_we    <= 1'b1;
                                r_rf_waddr <= r_base_reg;
                                r_rf_wdata <= r_base + w_span;
                            end
                        end
                    endcase
                    r_state <= S_DONE;
                end
                default: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = (r_mem_req & r_mem_we) ? rf_rdata : 32'd0;
    assign rf_raddr  = r_rf_raddr;
    assign rf_we     = r_rf_we;
    assign rf_waddr  = r_rf_waddr;
    assign rf_wdata  = r_rf_wdata;
    assign sp_we     = r_sp_we;
    assign sp_wdata  = r_sp_wdata;
    assign pc_we     = r_pc_we;
    assign pc_wdata  = r_pc_wdata;

endmodule

`default_nettype wire

// File: tb/tb_multi_reg_seq.sv
// ============================================================================
// Module   : tb_multi_reg_seq
// Brief    : Directed self-checking bench for multi_reg_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multi_reg_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [8:0]  reg_list;
    logic [31:0] base;
    logic [3:0]  base_reg;
    logic        busy, done, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [3:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        rf_we, sp_we, pc_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata, sp_wdata, pc_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    // Register file model: Rk reads as 0xA5A5_A500 | k.
    assign rf_rdata = 32'hA5A5_A500 | {28'd0, rf_raddr};

    multi_reg_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .reg_list  (reg_list),
        .base      (base),
        .base_reg  (base_reg),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .sp_we     (sp_we),
        .sp_wdata  (sp_wdata),
        .pc_we     (pc_we),
        .pc_wdata  (pc_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chkb({tag, ".busy"},    busy,    1'b0);
        chkb({tag, ".done"},    done,    1'b0);
        chkb({tag, ".mem_req"}, mem_req, 1'b0);
        chkb({tag, ".rf_we"},   rf_we,   1'b0);
        chkb({tag, ".sp_we"},   sp_we,   1'b0);
        chkb({tag, ".pc_we"},   pc_we,   1'b0);
        chk ({tag, ".mem_addr"},  mem_addr,  32'd0);
        chk ({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; op = 2'b00; reg_list = 9'd0;
        base = 32'd0; base_reg = 4'd0; mem_ack = 1'b0; mem_rdata = 32'd0;

        // ---------------- reset state
        #1;
        chk_quiet("rst0");
        step();
        chk_quiet("rst1");
        chk("rst.sp_wdata", sp_wdata, 32'd0);
        chk("rst.rf_raddr", {28'd0, rf_raddr}, 32'd0);

        // ---------------- PUSH {R0,R1,LR}, zero waits, start on first edge after release
        rst = 1'b1; start = 1'b1; op = 2'b00; reg_list = 9'h103;
        base = 32'h2000_0100; mem_ack = 1'b1;
        step();
        start = 1'b0;
        chkb("push.busy", busy, 1'b1);
        chkb("push.req0", mem_req, 1'b1);
        chkb("push.we0", mem_we, 1'b1);
        chk ("push.addr0", mem_addr, 32'h2000_00F4);
        chk ("push.wd0", mem_wdata, 32'hA5A5_A500);
        step();
        chk ("push.addr1", mem_addr, 32'h2000_00F8);
        chk ("push.wd1", mem_wdata, 32'hA5A5_A501);
        chkb("push.rfwe1", rf_we, 1'b0);
        step();
        chk ("push.addr2", mem_addr, 32'h2000_00FC);
        chk ("push.wd2", mem_wdata, 32'hA5A5_A50E);
        chk ("push.raddr2", {28'd0, rf_raddr}, 32'd14);
        step();
        mem_ack = 1'b0;
        chkb("push.wb.req", mem_req, 1'b0);
        chkb("push.wb.spwe", sp_we, 1'b0);
        step();
        chkb("push.spwe", sp_we, 1'b1);
        chk ("push.spwd", sp_wdata, 32'h2000_00F4);
        chkb("push.done_early", done, 1'b0);
        chkb("push.busy_wb", busy, 1'b1);
        step();
        chkb("push.done", done, 1'b1);
        chkb("push.busy_end", busy, 1'b0);
        chkb("push.spwe_off", sp_we, 1'b0);
        step();
        chkb("push.done_once", done, 1'b0);

        // ---------------- POP {R1,PC}
        start = 1'b1; op = 2'b01; reg_list = 9'h102; base = 32'h2000_00F4;
        step();
        start = 1'b0;
        chkb("pop.req0", mem_req, 1'b1);
        chkb("pop.we0", mem_we, 1'b0);
        chk ("pop.addr0", mem_addr, 32'h2000_00F4);
        chk ("pop.raddr0", {28'd0, rf_raddr}, 32'd1);
        chk ("pop.wdata_load", mem_wdata, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
        step();
        mem_rdata = 32'h0800_0101;
        chkb("pop.rfwe", rf_we, 1'b1);
        chk ("pop.rfwa", {28'd0, rf_waddr}, 32'd1);
        chk ("pop.rfwd", rf_wdata, 32'h0000_0055);
        chk ("pop.addr1", mem_addr, 32'h2000_00F8);
        step();
        mem_ack = 1'b0;
        chkb("pop.pcwe", pc_we, 1'b1);
        chk ("pop.pcwd", pc_wdata, 32'h0800_0100);
        chkb("pop.rfwe_off", rf_we, 1'b0);
        chkb("pop.req_off", mem_req, 1'b0);
        step();
        chkb("pop.spwe", sp_we, 1'b1);
        chk ("pop.spwd", sp_wdata, 32'h2000_00FC);
        chkb("pop.pcwe_off", pc_we, 1'b0);
        step();
        chkb("pop.done", done, 1'b1);

        // ---------------- LDM R2!,{R1,R2} with 3 wait states, ignored restart
        step();
        start = 1'b1; op = 2'b11; reg_list = 9'h006; base = 32'h0000_0100; base_reg = 4'd2;
        step();
        op = 2'b00; reg_list = 9'h0FF;
        for (int w = 0; w < 3; w++) begin
            step();
            chkb("ldm.req_w0", mem_req, 1'b1);
            chk ("ldm.addr_w0", mem_addr, 32'h0000_0100);
            chkb("ldm.we_w0", mem_we, 1'b0);
        end
        start = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0011;
        step();
        mem_ack = 1'b0;
        chkb("ldm.rfwe1", rf_we, 1'b1);
        chk ("ldm.rfwa1", {28'd0, rf_waddr}, 32'd1);
        chk ("ldm.rfwd1", rf_wdata, 32'h0000_0011);
        for (int w = 0; w < 3; w++) begin
            step();
            chk ("ldm.addr_w1", mem_addr, 32'h0000_0104);
            chkb("ldm.rfwe_w1", rf_we, 1'b0);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0000_0022;
        step();
        mem_ack = 1'b0;
        chkb("ldm.rfwe2", rf_we, 1'b1);
        chk ("ldm.rfwa2", {28'd0, rf_waddr}, 32'd2);
        chk ("ldm.rfwd2", rf_wdata, 32'h0000_0022);
        step();
        chkb("ldm.no_wb_rf", rf_we, 1'b0);
        chkb("ldm.no_wb_sp", sp_we, 1'b0);
        step();
        chkb("ldm.done", done, 1'b1);

        // ---------------- STM wrapping past 2^32
        start = 1'b1; op = 2'b10; reg_list = 9'h003; base = 32'hFFFF_FFFC; base_reg = 4'd5;
        mem_ack = 1'b1;
        step();
        start = 1'b0;
        chk ("stm.addr0", mem_addr, 32'hFFFF_FFFC);
        chk ("stm.wd0", mem_wdata, 32'hA5A5_A500);
        step();
        chk ("stm.addr1", mem_addr, 32'h0000_0000);
        chk ("stm.wd1", mem_wdata, 32'hA5A5_A501);
        step();
        mem_ack = 1'b0;
        chkb("stm.req_off", mem_req, 1'b0);
        step();
        chkb("stm.rfwe", rf_we, 1'b1);
        chk ("stm.rfwa", {28'd0, rf_waddr}, 32'd5);
        chk ("stm.rfwd", rf_wdata, 32'h0000_0004);
        step();
        chkb("stm.done", done, 1'b1);

        // ---------------- empty list (STM ignores bit8), stray ack while idle
        start = 1'b1; op = 2'b10; reg_list = 9'h100; mem_ack = 1'b1;
        step();
        start = 1'b0;
        chkb("empty.busy", busy, 1'b1);
        chkb("empty.done_early", done, 1'b0);
        chkb("empty.req", mem_req, 1'b0);
        step();
        chkb("empty.done", done, 1'b1);
        chkb("empty.req2", mem_req, 1'b0);
        chkb("empty.rfwe", rf_we, 1'b0);
        chkb("empty.spwe", sp_we, 1'b0);
        step();
        chk_quiet("empty.after");
        mem_ack = 1'b0;

        // ---------------- reset during the 2nd transfer of a 4-register PUSH
        start = 1'b1; op = 2'b00; reg_list = 9'h00F; base = 32'h0000_1000; mem_ack = 1'b1;
        step();
        start = 1'b0;
        chk ("abort.addr0", mem_addr, 32'h0000_0FF0);
        step();
        chk ("abort.addr1", mem_addr, 32'h0000_0FF4);
        #2;
        rst = 1'b0;
        #1;
        chk_quiet("abort.async");
        step();
        chk_quiet("abort.held");
        rst = 1'b1; start = 1'b1; reg_list = 9'h001;
        step();
        start = 1'b0;
        chk ("rerun.addr", mem_addr, 32'h0000_0FFC);
        chk ("rerun.wd", mem_wdata, 32'hA5A5_A500);
        step();
        mem_ack = 1'b0;
        step();
        chkb("rerun.spwe", sp_we, 1'b1);
        chk ("rerun.spwd", sp_wdata, 32'h0000_0FFC);
        step();
        chkb("rerun.done", done, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multi_reg_seq.md
MULTI_REG_SEQ -- requirements
Module: multi_reg_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; rst=0 forces the reset state immediately.
REQ-003 start  input  1  one-cycle request to begin a multi-register transfer; sampled only in IDLE.
REQ-004 op  input  2  operation select: 00 PUSH, 01 POP, 10 STM (increment-after), 11 LDM (increment-after).
REQ-005 reg_list  input  9  register list: bits[7:0] select R0-R7; bit8 selects LR for PUSH and PC for POP; bit8 is ignored for STM/LDM.
REQ-006 base  input  32  base address (SP value for PUSH/POP, Rn value for STM/LDM); captured at start.
REQ-007 base_reg  input  4  Rn index for STM/LDM writeback; captured at start.
REQ-008 busy  output  1  high from the cycle after an accepted start until the cycle done is high.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 mem_req  output  1  memory transfer request.
REQ-011 mem_we  output  1  1 = store, 0 = load; valid while mem_req=1.
REQ-012 mem_addr  output  32  word address of the current transfer.
REQ-013 mem_wdata  output  32  store data; equals rf_rdata.
REQ-014 mem_ack  input  1  transfer completes in a cycle where mem_req=1 and mem_ack=1.
REQ-015 mem_rdata  input  32  load data; valid in the ack cycle.
REQ-016 rf_raddr  output  4  register-file read index of the current register.
REQ-017 rf_rdata  input  32  combinational register-file read data for rf_raddr.
REQ-018 rf_we / rf_waddr / rf_wdata  output  1/4/32  general-register write port.
REQ-019 sp_we / sp_wdata  output  1/32  stack-pointer load port.
REQ-020 pc_we / pc_wdata  output  1/32  program-counter branch load port (POP with PC).

Function
REQ-021 The block SHALL implement the states IDLE, XFER, WB, and DONE.
REQ-022 IDLE SHALL transition on start=1 as follows: to XFER if N>0, where N = popcount of the effective list (0..9); otherwise to DONE.
REQ-023 The block SHALL transfer registers in ascending index order (LR/PC last) at ascending word addresses, one per transfer.
REQ-024 The start address SHALL be base-4N for PUSH and base for POP/STM/LDM; each subsequent address SHALL be the previous address +4; all arithmetic SHALL be modulo 2^32.
REQ-025 In XFER, mem_req, mem_addr, mem_we and mem_wdata SHALL remain stable until the ack cycle; the next transfer's mem_req SHALL be driven in the cycle following the ack.
REQ-026 On a load ack, the block SHALL pulse rf_we for one cycle with rf_waddr set to the register index and rf_wdata = mem_rdata; for PC, it SHALL instead pulse pc_we with pc_wdata = mem_rdata & 32'hFFFFFFFE.
REQ-027 After the last ack, the state SHALL go to WB for exactly one cycle.
REQ-028 In WB, the block SHALL perform the writeback as follows:
  - PUSH: sp_we=1, sp_wdata = base-4N.
  - POP: sp_we=1, sp_wdata = base+4N.
  - STM: rf_we=1 to base_reg with base+4N.
  - LDM: rf_we=1 to base_reg with base+4N only when base_reg is not in the list; otherwise no write.
REQ-029 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE; busy SHALL be 0 in IDLE.
REQ-030 An empty list SHALL produce no mem_req and no writeback, with done=1 two cycles after start.
REQ-031 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 No more than one of rf_we, sp_we and pc_we SHALL be high in any cycle.
REQ-034 The block SHALL support unbounded memory wait states; there is no timeout.

Reset
REQ-035 While rst=0, the state SHALL be IDLE and every output SHALL be 0, including busy, done, mem_req, all write enables, all addresses and all data.
REQ-036 Reset asserted mid-operation SHALL abort immediately: no further mem_req or writeback; register writes already performed are kept.
REQ-037 The first start SHALL be accepted on the first rising edge after rst returns to 1.

Verification
REQ-038 PUSH, base=0x2000_0100, list=0x103 (R0,R1,LR), ack with zero waits -> stores at 0x...F4/F8/FC of R0,R1,R14; sp_we with 0x2000_00F4; done pulses once.
REQ-039 POP, base=0x2000_00F4, list=0x102 (R1,PC), rdata 0x55/0x0800_0101 -> rf_we R1=0x55; pc_we 0x0800_0100; sp_wdata=0x2000_00FC.
REQ-040 LDM, base_reg=2, base=0x100, list=0x06, with 3 wait states per ack -> mem_addr held stable during waits; R1,R2 loaded; no base writeback.
REQ-041 STM, base=0xFFFF_FFFC, list=0x03 -> addresses 0xFFFF_FFFC then 0x0000_0000; Rn writeback 0x0000_0004.
REQ-042 Empty list with start -> done=1 two cycles later; mem_req and all write enables stay 0.
REQ-043 rst pulled low during the 2nd transfer of a 4-register PUSH -> all outputs 0 asynchronously; after release, a new start completes normally.
